button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Multi-channel successor to the single-input debouncer for board buttons and switches. Each channel has:
- an input synchroniser and a polarity option
- a debounce counter
- press/release edge pulses
- a per-channel press FSM that classifies short clicks and long presses, and generates auto-repeat ticks while a button is held.

It sits between the raw top-level button pins and the GPU control and UI logic.

Parameters:
NUM_CH, 4, number of independent input channels
CLK_PERIOD_NS, 10, clock period in ns; used only to derive cycle counts
DEBOUNCE_TIME_MS, 5, required stable time before clean output changes; DB_MAX = ceil(DEBOUNCE_TIME_MS*1e6/CLK_PERIOD_NS), must be >= 1
HOLD_TIME_MS, 500, press duration that qualifies as long; HOLD_MAX derived the same way, must be >= 1
REPEAT_TIME_MS, 100, auto-repeat period while held; REPEAT_MAX derived the same way; 0 disables repeat
SYNC_STAGES, 2, synchroniser flop depth, must be >= 2
ACTIVE_LOW, 0, 1 = pin reads 0 when pressed (input inverted after synchroniser)

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-high
dirty_in  input  NUM_CH  raw asynchronous pin levels
clean_out  output  NUM_CH  debounced pressed level (1 = pressed, after polarity)
press_out  output  NUM_CH  1-cycle pulse on clean_out 0->1
release_out  output  NUM_CH  1-cycle pulse on clean_out 1->0
click_out  output  NUM_CH  1-cycle pulse on release before HOLD_MAX reached
long_out  output  NUM_CH  1-cycle pulse when press reaches HOLD_MAX
repeat_out  output  NUM_CH  1-cycle pulse every REPEAT_MAX cycles while in HELD

Behaviour:
- Reset:
  - Asynchronous, active-high; all flops clear immediately with no clock edge.
  - Synchroniser flops reset to the idle pin level (ACTIVE_LOW).
  - All outputs, counters and FSMs reset to 0 / IDLE. clean_out is 0 in reset; the input is never sampled in reset.
- Synchroniser and polarity:
  - Per channel: SYNC_STAGES flop chain.
  - s = last stage XOR ACTIVE_LOW.
- Debounce, per channel, with state stable_q (drives clean_out) and cnt of width $clog2(DB_MAX+1):
  - s == stable_q: cnt <= 0.
  - s != stable_q and cnt < DB_MAX-1: cnt <= cnt+1.
  - s != stable_q and cnt == DB_MAX-1: stable_q <= s; cnt <= 0.
  - Net effect: a change must persist DB_MAX consecutive samples; any glitch back restarts the count.
- Latency: clean_out changes on edge SYNC_STAGES+DB_MAX, counting the first edge that samples the settled pin as edge 1.
- Edge pulses:
  - press_out and release_out are registered, asserted in the same cycle clean_out first shows the new level, for exactly 1 cycle.
- Press FSM, per channel; states IDLE, PRESSED, HELD; hold counter hcnt saturates and never wraps:
  - IDLE -> PRESSED on the edge stable_q rises; hcnt <= 0.
  - PRESSED, still pressed: hcnt increments. When hcnt reaches HOLD_MAX-1 -> HELD with long_out=1 for 1 cycle; rcnt <= 0.
  - PRESSED, released: -> IDLE; click_out=1 coincident with release_out.
  - HELD, REPEAT_MAX>0: rcnt counts. At rcnt == REPEAT_MAX-1, repeat_out=1 for 1 cycle and rcnt <= 0. The first repeat comes REPEAT_MAX cycles after long_out.
  - HELD, released: -> IDLE; release_out only, with no click_out.
- Simultaneous events:
  - Channels are fully independent; any combination of pulses may occur in one cycle across channels.
  - Within one channel, long_out and release_out cannot coincide: release takes priority and yields click_out.
- Reset mid-operation: all pulses drop immediately. After deassertion, a still-pressed button re-qualifies through the full sync+debounce path and produces a fresh press_out.

Decomposition:
- Package button_pkg:
  - press FSM state enum (IDLE, PRESSED, HELD)
  - function ms_to_cycles(ms, period_ns), returning ceil, used for DB_MAX, HOLD_MAX and REPEAT_MAX.
- Sub-module button_channel: one channel containing the synchroniser, debounce, edge pulses and FSM.
- The top level is a generate loop over NUM_CH plus elaboration-time parameter checks (DB_MAX>=1, HOLD_MAX>=1, SYNC_STAGES>=2).

Test Plan:
All scenarios use NUM_CH=2, CLK_PERIOD_NS=1_000_000 (1 ms = 1 cycle), DEBOUNCE=4, HOLD=20, REPEAT=5, SYNC=2, ACTIVE_LOW=0.
1. dirty_in[0] toggles every 2 cycles for 20 cycles, then held at 1 -> clean_out[0] rises exactly on edge 6 after final settle; exactly one press_out[0]; no pulses during bounce.
2. Press ch0 held 10 cycles of clean, then released -> release_out[0] and click_out[0] in the same cycle; long_out[0] never asserts.
3. Press ch0 held 40 cycles -> long_out[0] at clean+20; repeat_out[0] at clean+25, +30, +35; release gives release_out[0] with no click_out[0].
4. Ch0 long press while ch1 does a short click overlapping it -> each channel's pulses match its solo run cycle-for-cycle.
5. Assert rst_in asynchronously mid-HELD -> all outputs 0 before the next clock edge. Hold the pin through deassert -> fresh press_out after 6 edges; no spurious release_out or click_out.
6. ACTIVE_LOW=1, pin idle high from reset -> no press_out. Pin driven low for 4 stable cycles -> clean_out=1 and press_out on edge 6.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and helpers for the multi-channel button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } press_state_e;

  // Rounds up, so a non-zero time never maps to zero cycles.
  function automatic int ms_to_cycles(input int ms, input int period_ns);
    longint num;
    longint den;
    num = longint'(ms) * longint'(1_000_000);
    den = longint'(period_ns);
    return int'((num + den - longint'(1)) / den);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, debouncer, press/release pulses and the
// click / long-press / auto-repeat classifier.
module button_channel
  import button_pkg::*;
#(
  parameter int DB_MAX      = 1,
  parameter int HOLD_MAX    = 1,
  parameter int REPEAT_MAX  = 0,
  parameter int SYNC_STAGES = 2,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic dirty_in,
  output logic clean_out,
  output logic press_out,
  output logic release_out,
  output logic click_out,
  output logic long_out,
  output logic repeat_out
);

  localparam int CW    = $clog2(DB_MAX + 1);
  localparam int HW    = $clog2(HOLD_MAX + 1);
  localparam int RW    = (REPEAT_MAX > 0) ? $clog2(REPEAT_MAX + 1) : 1;
  localparam int RLAST = (REPEAT_MAX > 0) ? REPEAT_MAX - 1 : 0;

  localparam logic [CW-1:0] DB_LAST   = CW'(DB_MAX - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [RW-1:0] RPT_LAST  = RW'(RLAST);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  press_state_e  state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          click_q, click_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;

  // Synchroniser idles at the unpressed pin level so reset never looks like a press.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], dirty_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  always_comb begin
    stable_d  = stable_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s != stable_q) begin
      if (cnt_q == DB_LAST) begin
        stable_d  = s;
        press_d   = s;
        release_d = ~s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // A release on the same edge the hold limit is reached wins and counts as a click.
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    rcnt_d   = rcnt_q;
    click_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_d) begin
          state_d = PRESSED;
          hcnt_d  = '0;
        end
      end
      PRESSED: begin
        if (release_d) begin
          state_d = IDLE;
          click_d = 1'b1;
        end else if (hcnt_q == HOLD_LAST) begin
          state_d = HELD;
          long_d  = 1'b1;
          rcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      HELD: begin
        if (release_d) begin
          state_d = IDLE;
        end else if (REPEAT_MAX > 0) begin
          if (rcnt_q == RPT_LAST) begin
            repeat_d = 1'b1;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      state_q   <= IDLE;
      hcnt_q    <= '0;
      rcnt_q    <= '0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      rcnt_q    <= rcnt_d;
      click_q   <= click_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign clean_out   = stable_q;
  assign press_out   = press_q;
  assign release_out = release_q;
  assign click_out   = click_q;
  assign long_out    = long_q;
  assign repeat_out  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: converts millisecond timings to cycle
// counts and replicates one independent channel per input pin.
module button_conditioner
  import button_pkg::*;
#(
  parameter int NUM_CH           = 4,
  parameter int CLK_PERIOD_NS    = 10,
  parameter int DEBOUNCE_TIME_MS = 5,
  parameter int HOLD_TIME_MS     = 500,
  parameter int REPEAT_TIME_MS   = 100,
  parameter int SYNC_STAGES      = 2,
  parameter int ACTIVE_LOW       = 0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [NUM_CH-1:0] dirty_in,
  output logic [NUM_CH-1:0] clean_out,
  output logic [NUM_CH-1:0] press_out,
  output logic [NUM_CH-1:0] release_out,
  output logic [NUM_CH-1:0] click_out,
  output logic [NUM_CH-1:0] long_out,
  output logic [NUM_CH-1:0] repeat_out
);

  localparam int DB_MAX     = ms_to_cycles(DEBOUNCE_TIME_MS, CLK_PERIOD_NS);
  localparam int HOLD_MAX   = ms_to_cycles(HOLD_TIME_MS, CLK_PERIOD_NS);
  localparam int REPEAT_MAX = ms_to_cycles(REPEAT_TIME_MS, CLK_PERIOD_NS);

  if (DB_MAX < 1) begin : g_bad_db
    $error("button_conditioner: DB_MAX must be >= 1");
  end
  if (HOLD_MAX < 1) begin : g_bad_hold
    $error("button_conditioner: HOLD_MAX must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_conditioner: SYNC_STAGES must be >= 2");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    button_channel #(
      .DB_MAX      (DB_MAX),
      .HOLD_MAX    (HOLD_MAX),
      .REPEAT_MAX  (REPEAT_MAX),
      .SYNC_STAGES (SYNC_STAGES),
      .ACTIVE_LOW  (ACTIVE_LOW != 0)
    ) u_ch (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .dirty_in    (dirty_in[i]),
      .clean_out   (clean_out[i]),
      .press_out   (press_out[i]),
      .release_out (release_out[i]),
      .click_out   (click_out[i]),
      .long_out    (long_out[i]),
      .repeat_out  (repeat_out[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: an active-high and an active-low instance,
// checked every cycle against a sliding-window model of the button rules.
module tb_button_conditioner;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int REP  = 5;
  localparam int NL   = 4;
  localparam int MAXN = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dirtyA = 2'b00;
  logic [1:0] dirtyB = 2'b11;
  logic [1:0] cleanA, pressA, releaseA, clickA, longA, repeatA;
  logic [1:0] cleanB, pressB, releaseB, clickB, longB, repeatB;

  int compared = 0;
  int mismatched = 0;
  int cycleCnt = 0;

  int pressCnt0 = 0, releaseCnt0 = 0, clickCnt0 = 0, longCnt0 = 0;
  int clickCnt1 = 0, pressCntB0 = 0, lastClickAt = -1;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_CH(2), .CLK_PERIOD_NS(1_000_000), .DEBOUNCE_TIME_MS(DB), .HOLD_TIME_MS(HOLD),
    .REPEAT_TIME_MS(REP), .SYNC_STAGES(SYNC), .ACTIVE_LOW(0)
  ) dutA (
    .clk_in(clk), .rst_in(rst), .dirty_in(dirtyA), .clean_out(cleanA), .press_out(pressA),
    .release_out(releaseA), .click_out(clickA), .long_out(longA), .repeat_out(repeatA)
  );

  button_conditioner #(
    .NUM_CH(2), .CLK_PERIOD_NS(1_000_000), .DEBOUNCE_TIME_MS(DB), .HOLD_TIME_MS(HOLD),
    .REPEAT_TIME_MS(REP), .SYNC_STAGES(SYNC), .ACTIVE_LOW(1)
  ) dutB (
    .clk_in(clk), .rst_in(rst), .dirty_in(dirtyB), .clean_out(cleanB), .press_out(pressB),
    .release_out(releaseB), .click_out(clickB), .long_out(longB), .repeat_out(repeatB)
  );

  // Lanes 0-1 are dutA channels, lanes 2-3 are dutB channels.
  bit sHist[NL][MAXN];
  int n = 0;
  bit mClean[NL], mPress[NL], mRelease[NL], mClick[NL], mLong[NL], mRepeat[NL];
  int mStart[NL];

  function automatic bit sAfter(input int l, input int k);
    int idx;
    idx = k - (SYNC - 1);
    return (idx >= 1 && idx < MAXN) ? sHist[l][idx] : 1'b0;
  endfunction

  function automatic bit pinOf(input int l);
    return (l < 2) ? dirtyA[l] : dirtyB[l-2];
  endfunction

  // Clean level flips once the last DB synchronised samples all disagree with it;
  // pulse classes follow from the age of the current press.
  initial forever begin
    @(posedge clk);
    cycleCnt++;
    if (rst) begin
      n = 0;
      for (int l = 0; l < NL; l++) begin
        mClean[l] = 0; mPress[l] = 0; mRelease[l] = 0;
        mClick[l] = 0; mLong[l] = 0; mRepeat[l] = 0; mStart[l] = 0;
      end
    end else begin
      if (n < MAXN - 1) n++;
      for (int l = 0; l < NL; l++) begin
        bit flip;
        int age;
        sHist[l][n] = pinOf(l) ^ (l >= 2);
        flip = 1'b1;
        for (int k = n - DB; k < n; k++) if (sAfter(l, k) == mClean[l]) flip = 1'b0;
        if (flip) mClean[l] = ~mClean[l];
        mPress[l]   = flip & mClean[l];
        mRelease[l] = flip & ~mClean[l];
        if (mPress[l]) mStart[l] = n;
        age = n - mStart[l];
        mClick[l]  = mRelease[l] && (age <= HOLD);
        mLong[l]   = mClean[l] && (age == HOLD);
        mRepeat[l] = mClean[l] && (REP > 0) && (age > HOLD) && ((age - HOLD) % REP == 0);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [1:0] expVec(input int kind, input int base);
    logic [1:0] v;
    v = 2'b00;
    for (int c = 0; c < 2; c++) begin
      case (kind)
        0: v[c] = mClean[base+c];
        1: v[c] = mPress[base+c];
        2: v[c] = mRelease[base+c];
        3: v[c] = mClick[base+c];
        4: v[c] = mLong[base+c];
        default: v[c] = mRepeat[base+c];
      endcase
    end
    return rst ? 2'b00 : v;
  endfunction

  function automatic logic [1:0] actVec(input int kind, input bit isB);
    case (kind)
      0: return isB ? cleanB : cleanA;
      1: return isB ? pressB : pressA;
      2: return isB ? releaseB : releaseA;
      3: return isB ? clickB : clickA;
      4: return isB ? longB : longA;
      default: return isB ? repeatB : repeatA;
    endcase
  endfunction

  string kName[6] = '{"clean", "press", "release", "click", "long", "repeat"};

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 6; k++) begin
        checkOutput($sformatf("%s.%s cyc%0d", (d == 1) ? "B" : "A", kName[k], cycleCnt),
                    int'(actVec(k, d == 1)), int'(expVec(k, 2 * d)));
      end
    end
    if (!rst) begin
      pressCnt0   += int'(pressA[0]);
      releaseCnt0 += int'(releaseA[0]);
      clickCnt0   += int'(clickA[0]);
      longCnt0    += int'(longA[0]);
      clickCnt1   += int'(clickA[1]);
      pressCntB0  += int'(pressB[0]);
      if (clickA[0]) lastClickAt = cycleCnt;
    end
  end

  function automatic bit sigOf(input int sel);
    case (sel)
      0: return cleanA[0];
      1: return pressA[0];
      2: return releaseA[0];
      3: return clickA[0];
      4: return longA[0];
      5: return repeatA[0];
      default: return pressB[0];
    endcase
  endfunction

  task automatic waitFor(input int sel, input int bound, input string name, output int at);
    at = -1000;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sigOf(sel)) begin
        at = cycleCnt;
        break;
      end
    end
    if (at == -1000) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: no pulse within %0d cycles, required one", name, bound);
    end
    #1;
  endtask

  task automatic applyStimulus(input int lane, input bit v, input int cycles);
    if (lane < 2) dirtyA[lane] = v;
    else dirtyB[lane-2] = v;
    repeat (cycles) @(negedge clk);
  endtask

  int remain[NL];

  initial begin
    int pAt, lAt, rAt, rpAt, settle, first, p0, r0, c0, c1, l0;

    repeat (2) @(negedge clk);
    checkOutput("rst_cleanA", int'(cleanA), 0);
    checkOutput("rst_cleanB_idle_high", int'(cleanB), 0);
    checkOutput("rst_pressA", int'(pressA), 0);
    checkOutput("rst_pressB", int'(pressB), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Bounce then settle high
    p0 = pressCnt0; r0 = releaseCnt0;
    for (int i = 0; i < 10; i++) applyStimulus(0, (i % 2) == 0, 2);
    dirtyA[0] = 1'b1;
    settle = cycleCnt + 1;
    waitFor(1, 20, "t1_press", pAt);
    checkOutput("t1_latency", pAt - settle, 5);
    checkOutput("t1_press_count", pressCnt0 - p0, 1);
    checkOutput("t1_no_release", releaseCnt0 - r0, 0);

    // Long press with repeats
    waitFor(4, 40, "t3_long", lAt);
    checkOutput("t3_long_delay", lAt - pAt, HOLD);
    for (int r = 1; r <= 3; r++) begin
      waitFor(5, 10, $sformatf("t3_repeat%0d", r), rpAt);
      checkOutput($sformatf("t3_repeat%0d_delay", r), rpAt - pAt, HOLD + REP * r);
    end
    repeat (5) @(negedge clk);
    c0 = clickCnt0;
    dirtyA[0] = 1'b0;
    settle = cycleCnt + 1;
    waitFor(2, 20, "t3_release", rAt);
    checkOutput("t3_release_latency", rAt - settle, 5);
    checkOutput("t3_no_click", clickCnt0 - c0, 0);

    // Short click
    repeat (10) @(negedge clk);
    l0 = longCnt0;
    dirtyA[0] = 1'b1;
    waitFor(1, 20, "t2_press", pAt);
    repeat (10) @(negedge clk);
    dirtyA[0] = 1'b0;
    waitFor(2, 20, "t2_release", rAt);
    checkOutput("t2_click_with_release", lastClickAt, rAt);
    checkOutput("t2_no_long", longCnt0 - l0, 0);

    // Overlapping long press on ch0 and click on ch1
    repeat (10) @(negedge clk);
    c1 = clickCnt1; l0 = longCnt0;
    applyStimulus(0, 1'b1, 8);
    applyStimulus(1, 1'b1, 12);
    applyStimulus(1, 1'b0, 40);
    applyStimulus(0, 1'b0, 20);
    checkOutput("t4_ch1_click", clickCnt1 - c1, 1);
    checkOutput("t4_ch0_long", longCnt0 - l0, 1);

    // Asynchronous reset while held
    dirtyA[0] = 1'b1;
    waitFor(4, 60, "t5_long", lAt);
    rst = 1'b1;
    #1;
    checkOutput("t5_async_clean", int'(cleanA), 0);
    checkOutput("t5_async_long", int'(longA), 0);
    checkOutput("t5_async_press", int'(pressA), 0);
    checkOutput("t5_async_repeat", int'(repeatA), 0);
    repeat (3) @(negedge clk);
    r0 = releaseCnt0; c0 = clickCnt0;
    rst = 1'b0;
    first = cycleCnt + 1;
    waitFor(1, 20, "t5_repress", pAt);
    checkOutput("t5_repress_latency", pAt - first, 5);
    checkOutput("t5_no_release", releaseCnt0 - r0, 0);
    checkOutput("t5_no_click", clickCnt0 - c0, 0);
    applyStimulus(0, 1'b0, 20);

    // Active-low channel: idle high, then exactly DB low samples
    checkOutput("t6_no_idle_press", pressCntB0, 0);
    dirtyB[0] = 1'b0;
    first = cycleCnt + 1;
    repeat (4) @(negedge clk);
    dirtyB[0] = 1'b1;
    waitFor(6, 10, "t6_press", pAt);
    checkOutput("t6_latency", pAt - first, 5);
    checkOutput("t6_clean", int'(cleanB[0]), 1);
    repeat (20) @(negedge clk);

    // Randomised bursts: glitches, clicks and long holds on every lane
    for (int l = 0; l < NL; l++) remain[l] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        if (remain[l] == 0) begin
          int cls;
          cls = int'($urandom_range(0, 9));
          if (cls < 3) remain[l] = int'($urandom_range(1, 3));
          else if (cls < 7) remain[l] = int'($urandom_range(5, 18));
          else remain[l] = int'($urandom_range(22, 60));
          if (l < 2) dirtyA[l] = ~dirtyA[l];
          else dirtyB[l-2] = ~dirtyB[l-2];
        end else begin
          remain[l]--;
        end
      end
      if (cyc == 1000 || cyc == 2000) begin
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
    end
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
